// File: rtl/bitonic_pkg.sv
// Shared definitions for the bitonic sorting path: direction encoding,
// fill-buffer state type, pad-key and frame-slice helpers.
package bitonic_pkg;

    // Direction encoding shared by loader, comparators and network stages
    localparam logic DIR_ASC  = 1'b1;
    localparam logic DIR_DESC = 1'b0;

    // Widest key any instance may use; callers size-cast pad_key() to W
    localparam int KEY_W_MAX = 64;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } fill_state_t;

    // Pad value that sorts to the tail: all-ones ascending, all-zeros descending.
    // Take the low W bits at the call site, e.g. W'(pad_key(dir)).
    function automatic logic [KEY_W_MAX-1:0] pad_key(input logic dir);
        return (dir == DIR_ASC) ? {KEY_W_MAX{1'b1}} : {KEY_W_MAX{1'b0}};
    endfunction

    // Bit offset of key k inside a packed frame of w-bit keys
    function automatic int unsigned slot_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/bitonic_frame_reg.sv
// Output holding register for one N-key frame with a valid/ready handshake.
// Also used downstream as the result collector stage.
module bitonic_frame_reg
    import bitonic_pkg::*;
#(
    parameter int W = 16,
    parameter int N = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [N*W-1:0]           load_frame,
    input  logic                     load_dir,
    input  logic [$clog2(N):0]       load_count,
    input  logic                     out_ready,
    output logic                     can_load,
    output logic                     out_valid,
    output logic [N*W-1:0]           out_frame,
    output logic                     out_direction,
    output logic [$clog2(N):0]       out_count
);

    logic                 valid_reg;
    logic [N*W-1:0]       frame_reg;
    logic                 dir_reg;
    logic [$clog2(N):0]   count_reg;

    // Register is free when empty or when its frame is taken this cycle
    assign can_load = !valid_reg || out_ready;

    // Capture a new frame on load; otherwise clear valid after a take and
    // keep the payload untouched so it stays stable under backpressure
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg <= 1'b0;
            frame_reg <= '0;
            dir_reg   <= DIR_DESC;
            count_reg <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            frame_reg <= load_frame;
            dir_reg   <= load_dir;
            count_reg <= load_count;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign out_valid     = valid_reg;
    assign out_frame     = frame_reg;
    assign out_direction = dir_reg;
    assign out_count     = count_reg;

endmodule

// File: rtl/bitonic_frame_loader.sv
// Packs a stream of W-bit keys into N-key frames, pads short frames so the
// padding sorts to the tail, and presents each frame with its direction.
module bitonic_frame_loader
    import bitonic_pkg::*;
#(
    parameter int W = 16,
    parameter int N = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [W-1:0]             in_data,
    input  logic                     in_last,
    input  logic                     in_dir,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N*W-1:0]           out_frame,
    output logic                     out_direction,
    output logic [$clog2(N):0]       out_count
);

    localparam int IW = $clog2(N);
    localparam int CW = IW + 1;
    localparam int FW = N * W;

    fill_state_t      state_reg;
    logic [IW-1:0]    idx_reg;
    logic             dir_reg;
    logic [FW-1:0]    fill_frame_reg;
    logic [CW-1:0]    fill_count_reg;

    logic             accept;
    logic             complete_now;
    logic             cur_dir;
    logic [W-1:0]     pad_val;
    logic [FW-1:0]    assembled_frame;
    logic [CW-1:0]    count_now;
    logic             can_load;
    logic             load;
    logic [FW-1:0]    load_frame;
    logic             load_dir;
    logic [CW-1:0]    load_count;

    // Ready depends only on registered state, never on out_ready
    assign in_ready = (state_reg == ST_FILL);

    assign accept       = in_valid && in_ready;
    assign cur_dir      = (idx_reg == '0) ? in_dir : dir_reg;
    assign complete_now = accept && ((idx_reg == IW'(N - 1)) || in_last);
    assign pad_val      = W'(pad_key(cur_dir));
    assign count_now    = CW'(idx_reg) + CW'(1);

    // Frame as it stands after this accept: earlier slots from the buffer,
    // the incoming key at idx, pad keys above it
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slot
            localparam int LSB = slot_lsb(gi, W);
            assign assembled_frame[LSB +: W] =
                (gi < int'(idx_reg))  ? fill_frame_reg[LSB +: W] :
                (gi == int'(idx_reg)) ? in_data :
                                        pad_val;
        end
    endgenerate

    // A held frame has priority; a frame completing now goes straight
    // through when the output register is free
    always_comb begin
        if (state_reg == ST_HOLD) begin
            load       = can_load;
            load_frame = fill_frame_reg;
            load_dir   = dir_reg;
            load_count = fill_count_reg;
        end else begin
            load       = complete_now && can_load;
            load_frame = assembled_frame;
            load_dir   = cur_dir;
            load_count = count_now;
        end
    end

    // Fill buffer, slot index and FILL/HOLD sequencing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_FILL;
            idx_reg        <= '0;
            dir_reg        <= DIR_DESC;
            fill_frame_reg <= '0;
            fill_count_reg <= '0;
        end else begin
            case (state_reg)
                ST_FILL: begin
                    if (accept) begin
                        fill_frame_reg <= assembled_frame;
                        fill_count_reg <= count_now;
                        dir_reg        <= cur_dir;
                        if (complete_now) begin
                            idx_reg <= '0;
                            if (!can_load) begin
                                state_reg <= ST_HOLD;
                            end
                        end else begin
                            idx_reg <= idx_reg + IW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (can_load) begin
                        state_reg <= ST_FILL;
                    end
                end
                default: begin
                    state_reg <= ST_FILL;
                end
            endcase
        end
    end

    bitonic_frame_reg #(
        .W (W),
        .N (N)
    ) u_frame_reg (
        .clk           (clk),
        .rst           (rst),
        .load          (load),
        .load_frame    (load_frame),
        .load_dir      (load_dir),
        .load_count    (load_count),
        .out_ready     (out_ready),
        .can_load      (can_load),
        .out_valid     (out_valid),
        .out_frame     (out_frame),
        .out_direction (out_direction),
        .out_count     (out_count)
    );

endmodule

// File: tb/tb_bitonic_frame_loader.sv
// Bench for bitonic_frame_loader: directed checks plus a scoreboard fed by an
// input-side frame model and drained by an output-side monitor.
module tb_bitonic_frame_loader;

    localparam int W  = 16;
    localparam int N  = 2;
    localparam int CW = $clog2(N) + 1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid = 1'b0;
    logic [W-1:0]       in_data = '0;
    logic               in_last = 1'b0;
    logic               in_dir = 1'b0;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [N*W-1:0]     out_frame;
    logic               out_direction;
    logic [CW-1:0]      out_count;

    typedef struct {
        logic [N*W-1:0] frame;
        logic           dir;
        logic [CW-1:0]  count;
    } exp_t;

    exp_t               sb_q[$];
    exp_t               m_exp;
    exp_t               m_got;
    logic [W-1:0]       m_keys [N];
    int                 m_idx = 0;
    logic               m_dir = 1'b0;
    int                 accepts = 0;
    int                 cycle = 0;
    int                 n_compared = 0;
    int                 n_mismatched = 0;

    bitonic_frame_loader #(.W(W), .N(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_last       (in_last),
        .in_dir        (in_dir),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_frame     (out_frame),
        .out_direction (out_direction),
        .out_count     (out_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Offer one key from posedge+1 and return at posedge+1 after it is accepted
    task automatic send_key(input logic [W-1:0] d, input logic last, input logic dir);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_dir   = dir;
        @(negedge clk);
        while (!in_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check_eq("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Input model pushes expected frames; output side pops and compares
    always @(negedge clk) begin
        if (!rst) begin
            m_idx = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_underflow", 64'd1, 64'd0);
                end else begin
                    m_got = sb_q.pop_front();
                    check_eq("sb_frame", out_frame, m_got.frame);
                    check_eq("sb_dir", out_direction, m_got.dir);
                    check_eq("sb_count", out_count, m_got.count);
                end
            end
            if (in_valid && in_ready) begin
                accepts++;
                if (m_idx == 0) m_dir = in_dir;
                m_keys[m_idx] = in_data;
                if (m_idx == N - 1 || in_last) begin
                    for (int k = 0; k < N; k++)
                        m_exp.frame[k*W +: W] = (k <= m_idx) ? m_keys[k] : {W{m_dir}};
                    m_exp.dir   = m_dir;
                    m_exp.count = CW'(m_idx + 1);
                    sb_q.push_back(m_exp);
                    m_idx = 0;
                end else begin
                    m_idx++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int a0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 64'd1);
        check_eq("rst_out_valid", out_valid, 64'd0);
        check_eq("rst_out_frame", out_frame, 64'd0);
        check_eq("rst_out_dir", out_direction, 64'd0);
        check_eq("rst_out_count", out_count, 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Full frame, then short frames in both directions
        out_ready = 1'b1;
        send_key(16'h0005, 1'b0, 1'b1);
        send_key(16'h0003, 1'b0, 1'b1);
        check_eq("full_valid", out_valid, 64'd1);
        check_eq("full_frame", out_frame, 64'h0003_0005);
        check_eq("full_count", out_count, 64'd2);
        check_eq("full_dir", out_direction, 64'd1);
        send_key(16'h00A0, 1'b1, 1'b1);
        check_eq("short_asc_frame", out_frame, 64'hFFFF_00A0);
        check_eq("short_asc_count", out_count, 64'd1);
        send_key(16'h00A0, 1'b1, 1'b0);
        check_eq("short_desc_frame", out_frame, 64'h0000_00A0);
        check_eq("short_desc_dir", out_direction, 64'd0);

        // Direction latched with the first key of a frame
        send_key(16'h0001, 1'b0, 1'b1);
        send_key(16'h0002, 1'b1, 1'b0);
        check_eq("dirlatch_dir", out_direction, 64'd1);
        check_eq("dirlatch_frame", out_frame, 64'h0002_0001);

        // Backpressure: two frames absorbed, third blocked until one take
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        send_key(16'h0011, 1'b0, 1'b1);
        send_key(16'h0022, 1'b0, 1'b1);
        send_key(16'h0033, 1'b0, 1'b0);
        send_key(16'h0044, 1'b0, 1'b0);
        check_eq("bp_in_ready_low", in_ready, 64'd0);
        check_eq("bp_frame1", out_frame, 64'h0022_0011);
        fork
            begin
                send_key(16'h0055, 1'b0, 1'b1);
                send_key(16'h0066, 1'b1, 1'b1);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                check_eq("bp_still_blocked", in_ready, 64'd0);
                check_eq("bp_frame1_stable", out_frame, 64'h0022_0011);
                check_eq("bp_dir1_stable", out_direction, 64'd1);
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                check_eq("bp_frame2", out_frame, 64'h0044_0033);
                check_eq("bp_frame2_valid", out_valid, 64'd1);
                check_eq("bp_frame2_dir", out_direction, 64'd0);
                check_eq("bp_in_ready_back", in_ready, 64'd1);
            end
        join
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Streaming: one accept per cycle with random frame boundaries
        t0 = cycle;
        a0 = accepts;
        for (int i = 0; i < 100; i++)
            send_key(W'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom));
        check_eq("stream_cycles", 64'(cycle - t0), 64'd100);
        check_eq("stream_accepts", 64'(accepts - a0), 64'd100);
        repeat (4) @(posedge clk);
        #1;

        // Reset mid-frame
        send_key(16'h0077, 1'b0, 1'b1);
        rst = 1'b0;
        #1;
        check_eq("midrst_out_valid", out_valid, 64'd0);
        check_eq("midrst_out_frame", out_frame, 64'd0);
        check_eq("midrst_out_dir", out_direction, 64'd0);
        check_eq("midrst_out_count", out_count, 64'd0);
        check_eq("midrst_in_ready", in_ready, 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        send_key(16'h0088, 1'b0, 1'b0);
        send_key(16'h0099, 1'b0, 1'b0);
        check_eq("postrst_frame", out_frame, 64'h0099_0088);
        check_eq("postrst_count", out_count, 64'd2);
        check_eq("postrst_dir", out_direction, 64'd0);

        repeat (5) @(posedge clk);
        #1;
        check_eq("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/bitonic_frame_loader.md
# bitonic_frame_loader

Upstream feeder for the bitonic sorting network. Accepts W-bit keys one per cycle over a valid/ready stream, packs them into an N-key frame, and pads short frames so padding sorts to the tail. Presents each complete frame, with its sort direction, as a registered N*W vector. With the default N=2 it drives the 2W-bit `IN` and `direction` inputs of the first post-stage comparator.

## Interface
- `W`, 16, key width in bits
- `N`, 2, keys per frame; power of two, ≥2
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  input key valid
- `in_data`  in  W  input key
- `in_last`  in  1  accepted key is the last of its frame, whether or not the frame is full
- `in_dir`  in  1  sort direction; 1 = ascending, 0 = descending; sampled with the first key of each frame
- `in_ready`  out  1  loader can accept a key this cycle
- `out_valid`  out  1  `out_frame` holds a complete frame
- `out_ready`  in  1  consumer takes the frame this cycle
- `out_frame`  out  N*W  key k at bits [k*W +: W]
- `out_direction`  out  1  direction latched for this frame
- `out_count`  out  $clog2(N)+1  number of real, non-pad keys, 1..N

## Operation
- Two storage levels:
  - fill buffer, with slot index `idx` (0..N-1) and latched direction;
  - output register, which drives the `out_*` ports.
- Accept: `in_valid && in_ready` at a rising edge. The key goes to slot `idx`, then `idx` increments. On `idx==0` the loader also latches `in_dir`.
- Frame completes on an accept when `idx==N-1` or `in_last==1`. On completion, slots `idx+1..N-1` are padded:
  - all-ones if the direction is ascending;
  - all-zeros if descending.
- Fill-buffer states:
  - FILL: `in_ready=1`.
  - HOLD: complete frame waiting because the output register is occupied and not draining; `in_ready=0`.
- Transfer from fill buffer to output register happens when the frame is complete and the output register is empty or being drained this cycle (`out_valid && out_ready`).
  - If the transfer happens in the completion cycle, state stays FILL and `idx` returns to 0.
  - Otherwise the state goes to HOLD, and returns to FILL on the cycle the transfer occurs.
- Output handshake:
  - While `out_valid && !out_ready`, `out_frame`, `out_direction` and `out_count` are held stable.
  - `out_valid` drops after a take unless a new transfer happens in the same cycle.
- Keys are never dropped, duplicated or reordered.
- `in_last` on the N-th key behaves like a plain full frame.
- `in_valid` while `in_ready=0` is ignored; the source holds its data.
- Reset (asserted at any time, including mid-frame or while HOLD):
  - the partial frame is discarded and state is FILL with `idx=0`;
  - `in_ready=1`, `out_valid=0`, `out_frame=0`, `out_direction=0`, `out_count=0`.

## Timing
- Latency: `out_valid` rises in the cycle after the completing key is accepted.
- Sustained throughput: one key per cycle, with back-to-back frames and no bubble while `out_ready` stays high.
- Backpressure: with `out_ready=0`, the loader accepts one further complete frame into the fill buffer, then holds `in_ready=0`.
  - `in_ready` returns to 1 in the cycle after the output take that frees the output register.
- `in_ready` is a registered function of state only; there is no combinational path from `out_ready` to `in_ready`.
- Padding, count and direction are resolved in the completion cycle and are visible with `out_valid`.

## Structure
- Shared package `bitonic_pkg`:
  - `DIR_ASC=1'b1`, `DIR_DESC=1'b0`;
  - pad-value function `pad_key(dir)` parameterized by W;
  - the frame-slice helper.
  - The comparator and network stages use the same direction encoding.
- One sub-module: `bitonic_frame_reg`, the output holding register with its valid/ready logic, reusable downstream for the result collector.
- The fill buffer, `idx` counter and FILL/HOLD state live in the top module.

## Test plan
- Full frame, W=16, N=2, `out_ready=1`:
  - stimulus: keys 0x0005, 0x0003 (dir=1);
  - response: the cycle after the second accept, `out_frame=0x0003_0005`, `out_count=2`, `out_direction=1`.
- Short frame, ascending:
  - stimulus: key 0x00A0 with `in_last=1`, dir=1;
  - response: `out_frame=0xFFFF_00A0`, `out_count=1`.
  - Same with dir=0: `out_frame=0x0000_00A0`.
- Backpressure:
  - stimulus: `out_ready=0`, three frames offered;
  - response: frames 1 and 2 accepted, `in_ready=0` after frame 2, frame 1 held stable on outputs;
  - then release `out_ready` for one cycle: frame 1 leaves, frame 2 appears next cycle, `in_ready=1` next cycle.
- Streaming:
  - stimulus: 100 random keys with continuous valid and ready;
  - response: one accept per cycle, frames in order, scoreboard matches every key.
- Reset mid-frame:
  - stimulus: one key accepted, then `rst` low for 1 cycle;
  - response: outputs reach their reset values immediately, and the next two keys form a clean frame containing no stale key.
- Direction latch:
  - stimulus: `in_dir` toggled between the first and second keys of a frame;
  - response: `out_direction` equals the value sampled with the first key.
